display_scan_driver: RTL and testbench

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

---
 rtl/display_scan_driver.sv | 117 +++++++++++
 tb/tb_display_scan_driver.sv | 128 ++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit scan, BCD shadow register, registered outputs.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 is never suppressed).
module display_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_DARK  = 7'h7F;

  logic [PW-1:0]             presc_p0;
  logic [IW-1:0]             idx_p0;
  logic [4*NUM_DIGITS-1:0]   shadow_p0;
  logic                      slot_tick;
  logic [3:0]                cur_nib;
  logic                      suppress;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DARK;
    endcase
    return s;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] onehot_low(input logic [IW-1:0] idx);
    logic [NUM_DIGITS-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++) r[i] = (idx != IW'(i));
    return r;
  endfunction

  assign slot_tick = (presc_p0 == PRESC_MAX);

  always_comb begin
    cur_nib = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_p0 == IW'(i)) cur_nib = shadow_p0[4*i +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] hi_zero;
  logic                  zacc;

  // hi_zero[i]: nibble i and every nibble above it are zero
  always_comb begin
    hi_zero  = '0;
    zacc     = 1'b1;
    suppress = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc       = zacc & (shadow_p0[4*i +: 4] == 4'd0);
      hi_zero[i] = zacc;
    end
    for (int i = 1; i < NUM_DIGITS; i++)
      if (idx_p0 == IW'(i) && hi_zero[i]) suppress = 1'b1;
  end
`else
  assign suppress = 1'b0;
`endif

  // Stage 0: prescaler, scan index and shadow capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_p0  <= '0;
      idx_p0    <= '0;
      shadow_p0 <= '1;
    end else begin
      if (load) shadow_p0 <= bcd_in;
      if (slot_tick) begin
        presc_p0 <= '0;
        idx_p0   <= (idx_p0 == IDX_MAX) ? '0 : idx_p0 + 1'b1;
      end else begin
        presc_p0 <= presc_p0 + 1'b1;
      end
    end
  end

  // Stage 1: registered outputs from the pre-edge index and shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out    <= SEG_DARK;
      dig_en     <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= slot_tick && (idx_p0 == IDX_MAX);
      if (blank) begin
        seg_out <= SEG_DARK;
        dig_en  <= '1;
      end else begin
        seg_out <= suppress ? SEG_DARK : seg_decode(cur_nib);
        dig_en  <= onehot_low(idx_p0);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised and directed bench for display_scan_driver against a cycle-count reference model.
module tb_display_scan_driver;

  localparam int N  = 4;
  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        frame_tick;

  int          tests = 0;
  int          fails = 0;
  int          k = 0;
  logic [15:0] shadow_m = 16'hFFFF;
  logic [6:0]  segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  display_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .load(load), .blank(blank),
    .seg_out(seg_out), .dig_en(dig_en), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at k=%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int i);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = sh >> (4 * i);
    nib   = upper[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && upper == 16'h0000) return 7'h7F;
`endif
    if (nib > 4'd9) return 7'h7F;
    return segtab[nib];
  endfunction

  // One clock: inputs applied now (at a negedge), outputs checked 1 time unit after the posedge.
  task automatic step(input logic ld, input logic [15:0] val, input logic bl);
    int         i;
    logic [6:0] es;
    logic [3:0] ed;
    logic       ef;
    load = ld; bcd_in = val; blank = bl;
    i  = (k / CD) % N;
    ef = (((k + 1) % (CD * N)) == 0);
    if (bl) begin
      es = 7'h7F; ed = 4'hF;
    end else begin
      es = exp_seg(shadow_m, i);
      ed = ~(4'b0001 << i);
    end
    @(posedge clk); #1;
    if (ld) shadow_m = val;
    k++;
    chk("seg_out", 16'(seg_out), 16'(es));
    chk("dig_en", 16'(dig_en), 16'(ed));
    chk("frame_tick", 16'(frame_tick), 16'(ef));
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_seg"}, 16'(seg_out), 16'h007F);
    chk({tag, "_dig"}, 16'(dig_en), 16'h000F);
    chk({tag, "_frame"}, 16'(frame_tick), 16'h0000);
  endtask

  initial begin
    logic [15:0] v;
    @(negedge clk);
    check_reset_state("rst_hold0");
    @(negedge clk);
    check_reset_state("rst_hold1");
    reset = 1'b0; k = 0; shadow_m = 16'hFFFF;

    // idle scan after reset: all dark, enables walk E,D,B,7
    for (int s = 0; s < 36; s++) step(1'b0, 16'h0000, 1'b0);

    step(1'b1, 16'h1234, 1'b0);
    for (int s = 0; s < 20; s++) step(1'b0, 16'h0000, 1'b0);

    step(1'b1, 16'h0070, 1'b0);
    for (int s = 0; s < 20; s++) step(1'b0, 16'h0000, 1'b0);

    // 3-cycle blank starting mid-slot
    while ((k % CD) != 1) step(1'b0, 16'h0000, 1'b0);
    for (int s = 0; s < 3; s++) step(1'b0, 16'h0000, 1'b1);
    for (int s = 0; s < 12; s++) step(1'b0, 16'h0000, 1'b0);

    // load on the slot-tick edge
    while ((k % CD) != CD - 1) step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h00AB, 1'b0);
    for (int s = 0; s < 20; s++) step(1'b0, 16'h0000, 1'b0);

    for (int s = 0; s < 300; s++) begin
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(0, 3));
      step(($urandom_range(0, 7) == 0), v, ($urandom_range(0, 9) == 0));
    end

    // asynchronous reset mid-slot, checked before any clock edge
    while ((k % CD) != 2) step(1'b0, 16'h0000, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_state("rst_async");
    @(negedge clk);
    check_reset_state("rst_async_hold");
    reset = 1'b0; k = 0; shadow_m = 16'hFFFF;
    for (int s = 0; s < 20; s++) step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h9865, 1'b0);
    for (int s = 0; s < 20; s++) step(1'b0, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
